picomips_fetch: RTL and testbench
=================================

# picomips_fetch

Instruction fetch sequencer for the picoMIPS core. It sits at the other end of the opcode path from the instruction decoder: it drives a synchronous program memory, presents the current instruction and its opcode to the decoder, and advances, holds or redirects the program counter from the decoder's PCincr and branch controls. Branches redirect with zero bubbles because the next fetch address is combinational. Stall and halt are also handled here.

## Interface
- PSIZE, 6, program counter and memory address width; the PC wraps modulo 2^PSIZE.
- ISIZE, 24, instruction width; the opcode is bits [ISIZE-1:ISIZE-6].
- RESET_PC, 0, fetch address after reset.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- imem_addr  out  PSIZE  program memory read address, combinational from next-PC logic.
- imem_rdata  in  ISIZE  program memory data; it is the word at the address sampled at the previous rising edge (1-cycle latency).
- instr  out  ISIZE  current instruction; imem_rdata when instr_valid=1, else 0 (NOP).
- opcode  out  6  instr[ISIZE-1:ISIZE-6].
- instr_valid  out  1  instr/opcode are executable this cycle.
- instr_pc  out  PSIZE  address of the current instruction (registered).
- PCincr  in  1  decoder: advance to the sequential instruction.
- branch_abs  in  1  decoder: jump to branch_tgt.
- branch_rel  in  1  decoder: jump to instr_pc + branch_off.
- branch_tgt  in  PSIZE  absolute target.
- branch_off  in  PSIZE  two's-complement relative offset.
- stall  in  1  freeze the fetch state.
- halt  in  1  decoder: current instruction is HALT.
- halted  out  1  high in HALT state.
- instret  out  16  retired-instruction counter, wraps at 0xFFFF→0.

## Operation
- State machine has three states: FILL, RUN and HALT. Reset enters FILL.
- Reset values: instr_pc=RESET_PC, instr_valid=0, halted=0, instret=0. This gives imem_addr=RESET_PC and instr=0.
- FILL lasts one cycle:
  - imem_addr=instr_pc.
  - At the edge, the state goes to RUN and instr_valid becomes 1.
- RUN next-address priority (nxt drives imem_addr; instr_pc<=nxt at the edge):
  - halt: nxt=instr_pc. Go to HALT, instr_valid<=0, halted<=1.
  - stall: nxt=instr_pc. All registers hold; halt is ignored while stalled.
  - branch_abs: nxt=branch_tgt.
  - branch_rel: nxt=(instr_pc+branch_off) mod 2^PSIZE, with branch_off sign-extended.
  - PCincr: nxt=(instr_pc+1) mod 2^PSIZE.
  - Otherwise: nxt=instr_pc. The instruction is re-presented for multi-cycle use; this is not a retire.
- Retire:
  - A RUN cycle with stall=0 and any of halt, branch_abs, branch_rel or PCincr retires one instruction.
  - Each retire increments instret by 1.
- HALT state:
  - imem_addr=instr_pc and instr_valid=0.
  - All control inputs are ignored.
  - Only reset_n exits HALT.
- Controls are sampled only when instr_valid=1. In FILL and HALT they have no effect.

## Timing
- imem_addr is combinational from the state, instr_pc and the control inputs in the same cycle. instr_pc, instr_valid, halted and instret are registered.
- Redirect latency: the target instruction appears on instr one cycle after a branch/PCincr cycle. There are no bubbles for branches.
- First valid instruction: the first rising edge after reset release ends FILL. instr_valid=1 from the following cycle, with instr=mem[RESET_PC].
- Reset asserted mid-operation forces the reset values immediately, including imem_addr=RESET_PC, regardless of clk. Any stall or branch in flight is discarded.
- Wrap-around cases:
  - PC wrap: instr_pc=2^PSIZE-1 with PCincr gives 0.
  - Relative branch: the sum is truncated to PSIZE bits.
- Simultaneous branch_abs and branch_rel: branch_abs wins.
- Simultaneous stall and halt: stall wins. Halt takes effect in the first unstalled cycle.

## Test plan
- Reset and FILL: release reset with mem[0]=0x1C0005.
  - imem_addr=0 throughout.
  - instr_valid=0 for 1 cycle, then 1 with opcode=0x07, instr_pc=0, instret=0.
- Sequential run: hold PCincr=1 for 4 cycles.
  - instr_pc steps 0,1,2,3,4, with instr=mem[instr_pc] each cycle.
  - instret=4.
- Branches:
  - At instr_pc=4, branch_rel=1 with branch_off=6'b111110 (−2): next instr_pc=2, no invalid cycle.
  - At instr_pc=63 with PCincr: next instr_pc=0.
  - Asserting branch_abs with tgt=9 together with branch_rel: next instr_pc=9.
- Stall and hold:
  - stall=1 for 3 cycles with PCincr=1: instr_pc, instr and instret are unchanged.
  - PCincr=0 with no branch for 2 cycles: instr is re-presented and instret is unchanged.
- Halt: halt=1 at instr_pc=7.
  - Next cycle: halted=1, instr_valid=0, instr=0, imem_addr=7.
  - PCincr and branches are then ignored for 10 cycles.
  - instret has incremented by exactly 1 for the HALT instruction.
- Asynchronous reset mid-branch: drop reset_n between clock edges during branch_abs=1.
  - Outputs immediately return to the reset values, with instr_pc=RESET_PC.
  - After release, the FILL→RUN sequence repeats.

Source files
------------

// File: rtl/picomips_fetch.sv
// Instruction fetch sequencer for picoMIPS: drives a synchronous program memory,
// presents the current instruction to the decoder and steps/redirects/holds the PC.
module picomips_fetch #(
   parameter int               PSIZE    = 6,
   parameter int               ISIZE    = 24,
   parameter logic [PSIZE-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic [PSIZE-1:0] imem_addr,
   input  logic [ISIZE-1:0] imem_rdata,
   output logic [ISIZE-1:0] instr,
   output logic [5:0]       opcode,
   output logic             instr_valid,
   output logic [PSIZE-1:0] instr_pc,
   input  logic             PCincr,
   input  logic             branch_abs,
   input  logic             branch_rel,
   input  logic [PSIZE-1:0] branch_tgt,
   input  logic [PSIZE-1:0] branch_off,
   input  logic             stall,
   input  logic             halt,
   output logic             halted,
   output logic [15:0]      instret
);

   typedef enum logic [1:0] {S_FILL, S_RUN, S_HALT} state_t;

   state_t           r_state;
   logic [PSIZE-1:0] r_pc;
   logic             r_valid;
   logic             r_halted;
   logic [15:0]      r_instret;

   logic             w_run;
   logic             w_retire;
   logic [PSIZE-1:0] w_rel;
   logic [PSIZE-1:0] w_nxt;

   assign w_run    = (r_state == S_RUN);
   assign w_retire = w_run && !stall && (halt || branch_abs || branch_rel || PCincr);
   // Same-width add is the sign-extended sum truncated to PSIZE bits.
   assign w_rel    = r_pc + branch_off;

   always_comb begin
      w_nxt = r_pc;
      if (w_run && !stall && !halt) begin
         if (branch_abs)      w_nxt = branch_tgt;
         else if (branch_rel) w_nxt = w_rel;
         else if (PCincr)     w_nxt = r_pc + PSIZE'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_FILL;
         r_pc      <= RESET_PC;
         r_valid   <= 1'b0;
         r_halted  <= 1'b0;
         r_instret <= '0;
      end else begin
         case (r_state)
            S_FILL: begin
               r_state <= S_RUN;
               r_valid <= 1'b1;
            end
            S_RUN: begin
               if (!stall) begin
                  r_pc <= w_nxt;
                  if (w_retire) r_instret <= r_instret + 16'd1;
                  if (halt) begin
                     r_state  <= S_HALT;
                     r_valid  <= 1'b0;
                     r_halted <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_HALT;
            end
         endcase
      end
   end

   assign imem_addr   = w_nxt;
   assign instr       = r_valid ? imem_rdata : '0;
   assign opcode      = instr[ISIZE-1 -: 6];
   assign instr_valid = r_valid;
   assign instr_pc    = r_pc;
   assign halted      = r_halted;
   assign instret     = r_instret;

endmodule

// File: tb/tb_picomips_fetch.sv
// Directed bench for picomips_fetch with a 1-cycle-latency program memory model.
module tb_picomips_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [5:0]  imem_addr;
   logic [23:0] imem_rdata;
   logic [23:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic [5:0]  instr_pc;
   logic        PCincr, branch_abs, branch_rel, stall, halt;
   logic [5:0]  branch_tgt, branch_off;
   logic        halted;
   logic [15:0] instret;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   picomips_fetch dut (
      .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .instr_pc(instr_pc),
      .PCincr(PCincr), .branch_abs(branch_abs), .branch_rel(branch_rel),
      .branch_tgt(branch_tgt), .branch_off(branch_off), .stall(stall), .halt(halt),
      .halted(halted), .instret(instret)
   );

   function automatic logic [23:0] memw(input int i);
      if (i == 0) return 24'h1C0005;
      return {6'(i + 10), 18'(i * 5 + 3)};
   endfunction

   always @(posedge clk) imem_rdata <= memw(int'(imem_addr));

   task automatic clear_ctl();
      PCincr = 0; branch_abs = 0; branch_rel = 0; stall = 0; halt = 0;
      branch_tgt = 0; branch_off = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clear_ctl();
      reset_n = 0;
      #12;
      nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %0b want 0", instr_valid); end
      nvec++; if (imem_addr !== 6'd0) begin nerr++; $display("FAIL rst_addr got %0d want 0", imem_addr); end
      nvec++; if ({halted, instret, instr_pc, instr} !== '0) begin nerr++; $display("FAIL rst_regs got h=%0b ir=%0d pc=%0d i=%h want 0", halted, instret, instr_pc, instr); end
      tick();
      reset_n = 1;
      #1;
      nvec++; if (instr_valid !== 1'b0 || imem_addr !== 6'd0) begin nerr++; $display("FAIL fill got v=%0b a=%0d want v=0 a=0", instr_valid, imem_addr); end
      tick();
      nvec++; if (instr_valid !== 1'b1 || opcode !== 6'h07 || instr !== 24'h1C0005) begin nerr++; $display("FAIL first_instr got v=%0b op=%h i=%h want v=1 op=07 i=1c0005", instr_valid, opcode, instr); end
      nvec++; if (instr_pc !== 6'd0 || instret !== 16'd0 || imem_addr !== 6'd0) begin nerr++; $display("FAIL first_pc got pc=%0d ir=%0d a=%0d want 0 0 0", instr_pc, instret, imem_addr); end
   endtask

   task automatic test_sequential();
      PCincr = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         nvec++; if (imem_addr !== 6'(i + 1)) begin nerr++; $display("FAIL seq_addr got %0d want %0d", imem_addr, i + 1); end
         tick();
         nvec++; if (instr_pc !== 6'(i + 1) || instr !== memw(i + 1) || instr_valid !== 1'b1) begin nerr++; $display("FAIL seq_step got pc=%0d i=%h want pc=%0d i=%h", instr_pc, instr, i + 1, memw(i + 1)); end
      end
      PCincr = 0;
      nvec++; if (instret !== 16'd4) begin nerr++; $display("FAIL seq_instret got %0d want 4", instret); end
   endtask

   task automatic test_branches();
      branch_rel = 1; branch_off = 6'b111110;
      #1;
      nvec++; if (imem_addr !== 6'd2) begin nerr++; $display("FAIL rel_addr got %0d want 2", imem_addr); end
      tick();
      branch_rel = 0;
      nvec++; if (instr_pc !== 6'd2 || instr_valid !== 1'b1 || instr !== memw(2)) begin nerr++; $display("FAIL rel_pc got pc=%0d v=%0b i=%h want pc=2 v=1 i=%h", instr_pc, instr_valid, instr, memw(2)); end
      branch_abs = 1; branch_tgt = 6'd63;
      tick();
      branch_abs = 0; PCincr = 1;
      nvec++; if (instr_pc !== 6'd63 || instr !== memw(63)) begin nerr++; $display("FAIL abs63 got pc=%0d i=%h want 63 %h", instr_pc, instr, memw(63)); end
      tick();
      PCincr = 0;
      nvec++; if (instr_pc !== 6'd0 || instr !== memw(0)) begin nerr++; $display("FAIL wrap got pc=%0d i=%h want 0 %h", instr_pc, instr, memw(0)); end
      branch_abs = 1; branch_tgt = 6'd9; branch_rel = 1; branch_off = 6'd1;
      tick();
      clear_ctl();
      nvec++; if (instr_pc !== 6'd9 || instr !== memw(9)) begin nerr++; $display("FAIL abs_wins got pc=%0d i=%h want 9 %h", instr_pc, instr, memw(9)); end
      nvec++; if (instret !== 16'd8) begin nerr++; $display("FAIL br_instret got %0d want 8", instret); end
   endtask

   task automatic test_stall_hold();
      stall = 1; PCincr = 1; halt = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         nvec++; if (imem_addr !== 6'd9) begin nerr++; $display("FAIL stall_addr got %0d want 9", imem_addr); end
         tick();
         nvec++; if (instr_pc !== 6'd9 || instr !== memw(9) || instret !== 16'd8 || halted !== 1'b0) begin nerr++; $display("FAIL stall got pc=%0d i=%h ir=%0d h=%0b want 9 %h 8 0", instr_pc, instr, instret, halted, memw(9)); end
      end
      clear_ctl();
      for (int i = 0; i < 2; i++) begin
         tick();
         nvec++; if (instr_pc !== 6'd9 || instr !== memw(9) || instret !== 16'd8 || instr_valid !== 1'b1) begin nerr++; $display("FAIL hold got pc=%0d i=%h ir=%0d v=%0b want 9 %h 8 1", instr_pc, instr, instret, instr_valid, memw(9)); end
      end
   endtask

   task automatic test_halt();
      branch_abs = 1; branch_tgt = 6'd7;
      tick();
      clear_ctl();
      halt = 1;
      #1;
      nvec++; if (imem_addr !== 6'd7 || instret !== 16'd9) begin nerr++; $display("FAIL pre_halt got a=%0d ir=%0d want 7 9", imem_addr, instret); end
      tick();
      halt = 0;
      nvec++; if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== 24'd0 || imem_addr !== 6'd7) begin nerr++; $display("FAIL halt got h=%0b v=%0b i=%h a=%0d want 1 0 0 7", halted, instr_valid, instr, imem_addr); end
      PCincr = 1; branch_abs = 1; branch_tgt = 6'd20; branch_rel = 1; branch_off = 6'd3;
      for (int i = 0; i < 10; i++) begin
         tick();
         nvec++; if (halted !== 1'b1 || instr_pc !== 6'd7 || imem_addr !== 6'd7 || instret !== 16'd10 || instr_valid !== 1'b0) begin nerr++; $display("FAIL halted_hold got h=%0b pc=%0d a=%0d ir=%0d v=%0b want 1 7 7 10 0", halted, instr_pc, imem_addr, instret, instr_valid); end
      end
      clear_ctl();
   endtask

   task automatic test_async_reset();
      reset_n = 0; #3; reset_n = 1;
      tick();
      tick();
      branch_abs = 1; branch_tgt = 6'd33;
      tick();
      nvec++; if (instr_pc !== 6'd33 || instret !== 16'd1 || instr_valid !== 1'b1) begin nerr++; $display("FAIL re_run got pc=%0d ir=%0d v=%0b want 33 1 1", instr_pc, instret, instr_valid); end
      branch_tgt = 6'd12;
      #2;
      nvec++; if (imem_addr !== 6'd12) begin nerr++; $display("FAIL inflight_addr got %0d want 12", imem_addr); end
      reset_n = 0;
      #1;
      nvec++; if (imem_addr !== 6'd0 || instr_pc !== 6'd0 || instr_valid !== 1'b0 || instret !== 16'd0 || halted !== 1'b0 || instr !== 24'd0) begin nerr++; $display("FAIL async_rst got a=%0d pc=%0d v=%0b ir=%0d h=%0b i=%h want all 0", imem_addr, instr_pc, instr_valid, instret, halted, instr); end
      tick();
      clear_ctl();
      reset_n = 1;
      #1;
      nvec++; if (instr_valid !== 1'b0 || imem_addr !== 6'd0) begin nerr++; $display("FAIL refill got v=%0b a=%0d want 0 0", instr_valid, imem_addr); end
      tick();
      nvec++; if (instr_valid !== 1'b1 || instr_pc !== 6'd0 || instr !== 24'h1C0005) begin nerr++; $display("FAIL rerun got v=%0b pc=%0d i=%h want 1 0 1c0005", instr_valid, instr_pc, instr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branches();
      test_stall_hold();
      test_halt();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
